simple_circuit_selftest: RTL and testbench



---
 rtl/simple_circuit_pkg.sv | 35 +++
 rtl/simple_circuit_if.sv | 50 +++++
 rtl/simple_circuit_selftest.sv | 141 ++++++++++++++
 tb/tb_simple_circuit_selftest.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/simple_circuit_pkg.sv
// Shared definitions for the simple-circuit built-in self-test.
//
// Contents:
//   state_e        - sequencer states (IDLE, SETTLE, CHECK, DONE)
//   PAT_W          - width of a stimulus pattern {C,B,A}
//   RESP_W         - width of a response {y,x}
//   NUM_PAT        - number of stimulus patterns walked per run
//   expected_resp  - golden model of the logic under test:
//                    x = (A & B) | ~C, y = ~C
package simple_circuit_pkg;

  localparam int PAT_W   = 3;
  localparam int RESP_W  = 2;
  localparam int NUM_PAT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Golden response for one stimulus pattern. Bit 0 of pat is A, bit 2 is C;
  // the result is packed as {y, x} with x in bit 0.
  function automatic logic [RESP_W-1:0] expected_resp(input logic [PAT_W-1:0] pat);
    logic a;
    logic b;
    logic c;
    a = pat[0];
    b = pat[1];
    c = pat[2];
    return {~c, (a & b) | ~c};
  endfunction

endpackage

// File: rtl/simple_circuit_if.sv
// Bundle of the self-test sequencer's control, stimulus and status signals.
//
// Signals:
//   start      - request a new test run
//   stim_out   - {C,B,A} pattern driven into the logic under test
//   resp_in    - {y,x} returned by the logic under test
//   busy       - a run is in progress
//   done       - the last run has finished and results are valid
//   pass       - the finished run saw no mismatches
//   err_count  - number of mismatching patterns (0..8)
//   fail_vec   - bit p set when pattern p mismatched
//
// Modports:
//   master - the self-test sequencer
//   slave  - the surrounding top level / logic under test
interface simple_circuit_if;
  import simple_circuit_pkg::*;

  logic                 start;
  logic [PAT_W-1:0]     stim_out;
  logic [RESP_W-1:0]    resp_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [3:0]           err_count;
  logic [NUM_PAT-1:0]   fail_vec;

  modport master (
    input  start,
    input  resp_in,
    output stim_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec
  );

  modport slave (
    output start,
    output resp_in,
    input  stim_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec
  );

endinterface

// File: rtl/simple_circuit_selftest.sv
// Built-in self-test sequencer for the simple-circuit logic.
//
// Walks all eight {C,B,A} patterns through the logic under test, holds each
// one for SETTLE_CYCLES cycles, then spends one CHECK cycle comparing the
// response against the golden model. Mismatches are recorded per pattern in
// fail_vec and counted in err_count; pass is raised on completion when no
// pattern mismatched.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - simple_circuit_if master modport (start, stimulus, response, status)
//
// Parameter:
//   SETTLE_CYCLES - cycles each pattern is held before sampling (1..15)
module simple_circuit_selftest
  import simple_circuit_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  simple_circuit_if.master   bus
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [PAT_W-1:0] LAST_PAT    = PAT_W'(NUM_PAT - 1);

  state_e               state_q, state_d;
  logic [PAT_W-1:0]     pat_idx_q, pat_idx_d;
  logic [3:0]           settle_cnt_q, settle_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [3:0]           err_count_q, err_count_d;
  logic [NUM_PAT-1:0]   fail_vec_q, fail_vec_d;

  logic                 mismatch;
  logic [3:0]           err_next;
  logic [NUM_PAT-1:0]   fail_next;

  // Result of the pattern currently applied. Only consumed in CHECK, where
  // resp_in has had at least one full cycle to settle behind the registered
  // stimulus.
  always_comb begin
    mismatch  = (bus.resp_in != expected_resp(pat_idx_q));
    err_next  = err_count_q + 4'(mismatch);
    fail_next = fail_vec_q;
    if (mismatch) begin
      fail_next[pat_idx_q] = 1'b1;
    end
  end

  // Sequencer next-state logic. The stimulus is the pattern index itself, so
  // it advances on the same edge that re-enters SETTLE and naturally holds
  // the last pattern (7) once DONE is reached.
  always_comb begin
    state_d      = state_q;
    pat_idx_d    = pat_idx_q;
    settle_cnt_d = settle_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_vec_d   = fail_vec_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d      = SETTLE;
          pat_idx_d    = '0;
          settle_cnt_d = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_count_d  = '0;
          fail_vec_d   = '0;
        end
      end

      SETTLE: begin
        settle_cnt_d = settle_cnt_q + 4'd1;
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        err_count_d = err_next;
        fail_vec_d  = fail_next;
        if (pat_idx_q == LAST_PAT) begin
          // pass must include the verdict of this final pattern, so it is
          // derived from the updated count rather than the registered one.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == 4'd0);
        end else begin
          state_d      = SETTLE;
          pat_idx_d    = pat_idx_q + 1'b1;
          settle_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial run at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pat_idx_q    <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      pat_idx_q    <= pat_idx_d;
      settle_cnt_q <= settle_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign bus.stim_out  = pat_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_simple_circuit_selftest.sv
// Self-checking bench for simple_circuit_selftest.
//
// Two instances are exercised: dutA with the default settle time, whose
// response input comes from a programmable table (so faults can be planted
// per pattern), and dutB with SETTLE_CYCLES=1 driven by a fault-free model.
module tb_simple_circuit_selftest;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int testsRun    = 0;
  int testsFailed = 0;

  simple_circuit_if busA();
  simple_circuit_if busB();

  // Truth table of the logic under test as {y,x}, indexed by {C,B,A}.
  logic [1:0] goldenTab [8] = '{2'b11, 2'b11, 2'b11, 2'b11,
                                2'b00, 2'b00, 2'b00, 2'b01};
  // What the emulated logic under test actually returns for dutA.
  logic [1:0] respTab   [8] = '{2'b11, 2'b11, 2'b11, 2'b11,
                                2'b00, 2'b00, 2'b00, 2'b01};

  simple_circuit_selftest #(.SETTLE_CYCLES(2)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  simple_circuit_selftest #(.SETTLE_CYCLES(1)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Emulated combinational logic under test for each instance.
  always_comb busA.resp_in = respTab[busA.stim_out];
  always_comb busB.resp_in = goldenTab[busB.stim_out];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setStart(input int which, input logic value);
    if (which == 0) busA.start = value;
    else            busB.start = value;
  endtask

  task automatic getObs(input int which, output int stim, output int busy,
                        output int done, output int pass, output int err,
                        output int fail);
    if (which == 0) begin
      stim = busA.stim_out;  busy = busA.busy;       done = busA.done;
      pass = busA.pass;      err  = busA.err_count;  fail = busA.fail_vec;
    end else begin
      stim = busB.stim_out;  busy = busB.busy;       done = busB.done;
      pass = busB.pass;      err  = busB.err_count;  fail = busB.fail_vec;
    end
  endtask

  // One-cycle start pulse; the rising edge during the pulse is t0.
  task automatic applyStimulus(input int which);
    @(negedge clk);
    setStart(which, 1'b1);
    @(negedge clk);
    setStart(which, 1'b0);
  endtask

  task automatic checkAllZero(input int which, input string tag);
    int s, b, d, p, e, f;
    getObs(which, s, b, d, p, e, f);
    checkOutput({tag, " stim"}, s, 0);
    checkOutput({tag, " busy"}, b, 0);
    checkOutput({tag, " done"}, d, 0);
    checkOutput({tag, " pass"}, p, 0);
    checkOutput({tag, " err"},  e, 0);
    checkOutput({tag, " fail"}, f, 0);
  endtask

  // Follows a run from just after t0 to just after t0 + 8*(settle+1),
  // checking the stimulus schedule and status each cycle and the results at
  // the end. midAt > 0 pulses start during the run at cycle t0+midAt.
  task automatic runPattern(input int which, input int settle, input int midAt,
                            input int expFail, input bit holdStart, input string tag);
    int total;
    int expErr;
    int expStim;
    int s, b, d, p, e, f;
    total  = 8 * (settle + 1);
    expErr = $countones(expFail[7:0]);

    getObs(which, s, b, d, p, e, f);
    checkOutput({tag, " t0 stim"}, s, 0);
    checkOutput({tag, " t0 busy"}, b, 1);
    checkOutput({tag, " t0 done"}, d, 0);
    checkOutput({tag, " t0 err"},  e, 0);
    checkOutput({tag, " t0 fail"}, f, 0);

    for (int n = 1; n <= total; n++) begin
      @(negedge clk);
      setStart(which, (n == midAt));
      getObs(which, s, b, d, p, e, f);
      expStim = n / (settle + 1);
      if (expStim > 7) expStim = 7;
      checkOutput($sformatf("%s stim n=%0d", tag, n), s, expStim);
      checkOutput($sformatf("%s busy n=%0d", tag, n), b, (n < total) ? 1 : 0);
      checkOutput($sformatf("%s done n=%0d", tag, n), d, (n >= total) ? 1 : 0);
    end

    checkOutput({tag, " err_count"}, e, expErr);
    checkOutput({tag, " fail_vec"},  f, expFail);
    checkOutput({tag, " pass"},      p, (expErr == 0) ? 1 : 0);

    if (holdStart) setStart(which, 1'b1);
  endtask

  task automatic restoreResp();
    for (int i = 0; i < 8; i++) respTab[i] = goldenTab[i];
  endtask

  // Reference verdict: a pattern fails whenever the returned pair differs
  // from the truth table in any bit.
  function automatic int modelFailVec();
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      if (respTab[i] != goldenTab[i]) v = v | (1 << i);
    end
    return v;
  endfunction

  initial begin
    int s, b, d, p, e, f;
    busA.start = 1'b0;
    busB.start = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkAllZero(0, "resetA");
    checkAllZero(1, "resetB");
    rst = 1'b0;

    // Fault-free run with the default settle time.
    applyStimulus(0);
    runPattern(0, 2, 0, 8'h00, 1'b0, "good");

    // Response stuck at 2'b11: patterns 4..7 fail.
    for (int i = 0; i < 8; i++) respTab[i] = 2'b11;
    applyStimulus(0);
    runPattern(0, 2, 0, 8'hF0, 1'b0, "stuck11");

    // x inverted only on pattern 7.
    restoreResp();
    respTab[7] = 2'b00;
    applyStimulus(0);
    runPattern(0, 2, 0, 8'h80, 1'b0, "p7x");

    // Mid-run start ignored; then start in DONE clears the errors of the
    // previous run and repeats cleanly.
    restoreResp();
    applyStimulus(0);
    runPattern(0, 2, 10, 8'h00, 1'b0, "midstart");
    for (int i = 0; i < 8; i++) respTab[i] = 2'b11;
    applyStimulus(0);
    runPattern(0, 2, 0, 8'hF0, 1'b0, "rerun_bad");
    restoreResp();
    applyStimulus(0);
    runPattern(0, 2, 0, 8'h00, 1'b1, "b2b_first");

    // start held through DONE: done lasts one cycle and the next run starts.
    @(negedge clk);
    setStart(0, 1'b0);
    runPattern(0, 2, 0, 8'h00, 1'b0, "b2b_second");

    // Asynchronous reset in the middle of a failing run.
    for (int i = 0; i < 8; i++) respTab[i] = 2'b10;
    applyStimulus(0);
    repeat (13) @(negedge clk);
    getObs(0, s, b, d, p, e, f);
    checkOutput("prereset err", e, 4);
    #2 rst = 1'b1;
    #1 checkAllZero(0, "asyncrst");
    @(negedge clk);
    checkAllZero(0, "rsthold");
    rst = 1'b0;
    restoreResp();
    applyStimulus(0);
    runPattern(0, 2, 0, 8'h00, 1'b0, "afterrst");

    // Randomised per-pattern faults checked against the reference verdict.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        respTab[i] = goldenTab[i];
        if ($urandom_range(0, 2) == 0) respTab[i] = goldenTab[i] ^ 2'($urandom_range(1, 3));
      end
      applyStimulus(0);
      runPattern(0, 2, 0, modelFailVec(), 1'b0, $sformatf("rand%0d", r));
    end

    // Shortest settle time.
    applyStimulus(1);
    runPattern(1, 1, 0, 8'h00, 1'b0, "settle1");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
